spi_slave_byte: RTL



---
 rtl/spi_slave_byte.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_byte.sv
// -----------------------------------------------------------------------------
// spi_slave_byte
// Byte-oriented SPI responder that runs entirely in the sys_clk domain.
// sclk, mosi and n_cs are oversampled through synchronizers. Edges of sclk are
// detected from the synchronized level, so sclk never clocks any flop.
// Received bytes are pushed to a downstream FIFO write port. Transmit bytes are
// popped from a show-ahead FIFO and shifted out on miso, MSB first.
//
// Parameters:
//   CPOL        sclk idle level
//   CPHA        0: sample on leading edge, shift on trailing edge
//               1: shift on leading edge, sample on trailing edge
//   SYNC_STAGES synchronizer depth on sclk/mosi/n_cs (2..4)
//   IDLE_BYTE   byte shifted out when the tx FIFO is empty
//
// Ports:
//   sys_clk, n_rst      clock, asynchronous active-low reset
//   sclk, n_cs, mosi    SPI bus inputs from the master
//   miso                registered slave-out data
//   miso_oe             output enable, high while a frame is active
//                       (present only with SPI_SLAVE_MISO_OE_EN)
//   m_dout, m_wrreq     received byte and its one-cycle write strobe
//   m_full              downstream FIFO full
//   s_din, s_empty      show-ahead tx FIFO data and empty flag
//   s_rdreq             one-cycle pop, asserted in the cycle s_din is captured
//   frame_done          one-cycle pulse when n_cs deasserts
//   frame_len           complete bytes received in the last frame (saturating)
//   overflow            sticky: a byte was dropped because m_full was set
//
// Optional feature macro: SPI_SLAVE_MISO_OE_EN
//   Defined:   adds miso_oe; miso is forced to 0 outside a frame.
//   Undefined: miso holds its last value between frames.
// -----------------------------------------------------------------------------
module spi_slave_byte #(
   parameter bit         CPOL        = 1'b0,
   parameter bit         CPHA        = 1'b0,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
   input  logic       sys_clk,
   input  logic       n_rst,
   input  logic       sclk,
   input  logic       n_cs,
   input  logic       mosi,
   output logic       miso,
`ifdef SPI_SLAVE_MISO_OE_EN
   output logic       miso_oe,
`endif
   output logic [7:0] m_dout,
   output logic       m_wrreq,
   input  logic       m_full,
   input  logic [7:0] s_din,
   input  logic       s_empty,
   output logic       s_rdreq,
   output logic       frame_done,
   output logic [7:0] frame_len,
   output logic       overflow
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
   logic                   sclk_hist_q, sclk_hist_d;
   logic                   ncs_hist_q, ncs_hist_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             byte_cnt_q, byte_cnt_d;
   logic [7:0]             rx_shift_q, rx_shift_d;
   logic [7:0]             tx_shift_q, tx_shift_d;
   logic                   miso_q, miso_d;
   logic [7:0]             m_dout_q, m_dout_d;
   logic                   m_wrreq_q, m_wrreq_d;
   logic                   frame_done_q, frame_done_d;
   logic [7:0]             frame_len_q, frame_len_d;
   logic                   overflow_q, overflow_d;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic                   miso_oe_q, miso_oe_d;
`endif

   logic sclk_s, mosi_s, ncs_s;
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   logic ncs_fall, ncs_rise;
   logic load;
   logic [7:0] rx_byte;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

   // Leading edge leaves the idle level, trailing edge returns to it.
   assign lead_edge   = (sclk_s != CPOL) && (sclk_hist_q == CPOL);
   assign trail_edge  = (sclk_s == CPOL) && (sclk_hist_q != CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign ncs_fall    = !ncs_s && ncs_hist_q;
   assign ncs_rise    = ncs_s && !ncs_hist_q;

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ncs_sync_d   = {ncs_sync_q[SYNC_STAGES-2:0], n_cs};
      sclk_hist_d  = sclk_s;
      ncs_hist_d   = ncs_s;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      m_dout_d     = m_dout_q;
      m_wrreq_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len_q;
      overflow_d   = overflow_q;
      s_rdreq      = 1'b0;
      load         = 1'b0;
      rx_byte      = {rx_shift_q[6:0], mosi_s};

      case (state_q)
         IDLE: begin
            // sclk activity outside a frame is ignored.
            if (ncs_fall) begin
               state_d    = ACTIVE;
               bit_cnt_d  = 3'd0;
               byte_cnt_d = 8'd0;
               // CPHA=0 must present bit 7 before the first leading edge.
               load       = ~CPHA;
            end
         end
         ACTIVE: begin
            // Chip-select release takes priority over a coincident sclk edge;
            // any partially received byte is dropped.
            if (ncs_rise) begin
               state_d      = IDLE;
               bit_cnt_d    = 3'd0;
               frame_len_d  = byte_cnt_q;
               frame_done_d = 1'b1;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = rx_byte;
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     m_dout_d = rx_byte;
                     if (m_full) overflow_d = 1'b1;
                     else        m_wrreq_d  = 1'b1;
                     if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
                  end
               end
               // A byte boundary reloads instead of shifting.
               if (shift_edge) begin
                  if (bit_cnt_q == 3'd0) load = 1'b1;
                  else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
      endcase

      // The pop coincides with the capture because the tx FIFO is show-ahead.
      if (load) begin
         if (!s_empty) begin
            tx_shift_d = s_din;
            s_rdreq    = 1'b1;
         end else begin
            tx_shift_d = IDLE_BYTE;
         end
      end

`ifdef SPI_SLAVE_MISO_OE_EN
      miso_oe_d = (state_d == ACTIVE);
      miso_d    = (state_d == ACTIVE) ? tx_shift_d[7] : 1'b0;
`else
      miso_d    = tx_shift_d[7];
`endif
   end

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         sclk_sync_q  <= {SYNC_STAGES{CPOL}};
         mosi_sync_q  <= '0;
         ncs_sync_q   <= '1;
         sclk_hist_q  <= CPOL;
         ncs_hist_q   <= 1'b1;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 8'd0;
         rx_shift_q   <= 8'd0;
         tx_shift_q   <= 8'd0;
         miso_q       <= 1'b0;
         m_dout_q     <= 8'd0;
         m_wrreq_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_len_q  <= 8'd0;
         overflow_q   <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
         miso_oe_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         ncs_sync_q   <= ncs_sync_d;
         sclk_hist_q  <= sclk_hist_d;
         ncs_hist_q   <= ncs_hist_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         miso_q       <= miso_d;
         m_dout_q     <= m_dout_d;
         m_wrreq_q    <= m_wrreq_d;
         frame_done_q <= frame_done_d;
         frame_len_q  <= frame_len_d;
         overflow_q   <= overflow_d;
`ifdef SPI_SLAVE_MISO_OE_EN
         miso_oe_q    <= miso_oe_d;
`endif
      end
   end

   assign miso       = miso_q;
   assign m_dout     = m_dout_q;
   assign m_wrreq    = m_wrreq_q;
   assign frame_done = frame_done_q;
   assign frame_len  = frame_len_q;
   assign overflow   = overflow_q;
`ifdef SPI_SLAVE_MISO_OE_EN
   assign miso_oe    = miso_oe_q;
`endif

endmodule
